// File: rtl/sobel_column_builder_pkg.sv
// Shared image constants for the Sobel front end (column builder and filter).
// No logic; holds frame geometry, pixel/word widths and a counter-width helper.
// Backpressure: n/a.
package sobel_column_builder_pkg;

    localparam int IMG_WIDTH  = 720;
    localparam int IMG_HEIGHT = 540;
    localparam int PIX_DW     = 8;
    localparam int COL_DW     = 3 * PIX_DW;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_column_builder_line_buffer_ram.sv
// One image row of pixels, indexed by column.
// Read is combinational (same cycle), write lands on the rising edge.
// Backpressure: none; the owner gates wr_en.
module line_buffer_ram #(
    parameter int DEPTH = 720,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are never cleared: stale rows are masked by the priming rows upstream.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sobel_column_builder.sv
// Builds 3-pixel vertical column words {row r, row r-1, row r-2} from a raster pixel stream.
// Zero latency: the word is pushed in the same cycle its newest pixel is popped.
// Backpressure: a pixel is popped only when input is non-empty and output is not full.
module sobel_column_builder
    import sobel_column_builder_pkg::*;
#(
    parameter int WIDTH      = IMG_WIDTH,
    parameter int HEIGHT     = IMG_HEIGHT,
    parameter int DWIDTH_IN  = PIX_DW,
    parameter int DWIDTH_OUT = COL_DW
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  fifo_in_rd_en,
    input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
    input  logic                  fifo_in_empty,
    output logic                  fifo_out_wr_en,
    output logic [DWIDTH_OUT-1:0] fifo_out_din,
    input  logic                  fifo_out_full,
    output logic                  frame_done
);

    localparam int CW = cnt_bits(WIDTH);
    localparam int RW = cnt_bits(HEIGHT);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 frame_done_q, frame_done_d;
    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic                 rows_primed;
    logic [DWIDTH_IN-1:0] mid_rd;
    logic [DWIDTH_IN-1:0] old_rd;

    // Handshake and raster position: accept only when both sides can move.
    always_comb begin
        accept      = !reset && !fifo_in_empty && !fifo_out_full;
        last_col    = (col_q == CW'(WIDTH - 1));
        last_row    = (row_q == RW'(HEIGHT - 1));
        rows_primed = (int'(row_q) >= 2);

        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (accept) begin
            if (last_col) begin
                col_d        = '0;
                row_d        = last_row ? '0 : row_q + RW'(1);
                frame_done_d = last_row;
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position counters and the end-of-frame pulse; reset aborts the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row r-1 store: takes the incoming pixel.
    line_buffer_ram #(
        .DEPTH (WIDTH),
        .DW    (DWIDTH_IN),
        .AW    (CW)
    ) u_buf_mid (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr (col_q),
        .wr_data (fifo_in_dout),
        .rd_addr (col_q),
        .rd_data (mid_rd)
    );

    // Row r-2 store: takes what row r-1 held at this column before the update.
    line_buffer_ram #(
        .DEPTH (WIDTH),
        .DW    (DWIDTH_IN),
        .AW    (CW)
    ) u_buf_old (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr (col_q),
        .wr_data (mid_rd),
        .rd_addr (col_q),
        .rd_data (old_rd)
    );

    assign fifo_in_rd_en  = accept;
    assign fifo_out_wr_en = accept && rows_primed;
    assign fifo_out_din   = {fifo_in_dout, mid_rd, old_rd};
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sobel_column_builder.sv
module tb_sobel_column_builder;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int DI   = 8;
    localparam int DO   = 24;
    localparam int NPIX = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic          fifo_in_rd_en;
    logic [DI-1:0] fifo_in_dout;
    logic          fifo_in_empty;
    logic          fifo_out_wr_en;
    logic [DO-1:0] fifo_out_din;
    logic          fifo_out_full;
    logic          frame_done;

    always #5 clock = ~clock;

    sobel_column_builder #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DWIDTH_IN  (DI),
        .DWIDTH_OUT (DO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full),
        .frame_done     (frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position of the next pixel within the frame, and the
    // pixels of the current frame seen so far.
    int            frame_idx = 0;
    logic [DI-1:0] frame_pix [NPIX];
    logic          fd_exp = 1'b0;
    logic [DO-1:0] out_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock with the inputs already driven: sample at negedge, then advance.
    task automatic tick(output logic accepted);
        logic          acc;
        logic          wr;
        logic [DO-1:0] word;
        @(negedge clock);
        acc = !reset && !fifo_in_empty && !fifo_out_full;
        check_eq("rd_en", fifo_in_rd_en, acc);
        check_eq("frame_done", frame_done, fd_exp);
        wr = acc && (frame_idx >= 2 * W);
        check_eq("wr_en", fifo_out_wr_en, wr);
        if (wr) begin
            word = {fifo_in_dout, frame_pix[frame_idx - W], frame_pix[frame_idx - 2 * W]};
            check_eq("din", fifo_out_din, word);
        end
        if (fifo_out_wr_en === 1'b1) out_q.push_back(fifo_out_din);
        fd_exp = acc && (frame_idx == NPIX - 1);
        if (acc) begin
            frame_pix[frame_idx] = fifo_in_dout;
            frame_idx = (frame_idx == NPIX - 1) ? 0 : frame_idx + 1;
        end
        if (reset) frame_idx = 0;
        accepted = acc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int cycles);
        logic a;
        fifo_in_empty = 1'b1;
        fifo_out_full = 1'b0;
        repeat (cycles) tick(a);
    endtask

    task automatic do_reset(input int cycles);
        logic a;
        reset         = 1'b1;
        fifo_in_empty = 1'b0;
        fifo_out_full = 1'b0;
        fifo_in_dout  = 8'hAA;
        repeat (cycles) tick(a);
        reset         = 1'b0;
        fifo_in_empty = 1'b1;
    endtask

    // Present n pixels; stall_pix holds output full for 5 cycles on that pixel.
    task automatic feed(input int first, input int n, input int gap_pct,
                        input int full_pct, input int stall_pix, input bit rnd);
        logic acc;
        int   stalls;
        int   guard;
        for (int i = 0; i < n; i++) begin
            acc    = 1'b0;
            stalls = 0;
            guard  = 0;
            fifo_in_dout = rnd ? 8'($urandom) : 8'(first + i);
            while (!acc) begin
                fifo_in_empty = ($urandom_range(99) < gap_pct);
                fifo_out_full = ($urandom_range(99) < full_pct);
                if (i == stall_pix && stalls < 5) begin
                    fifo_in_empty = 1'b0;
                    fifo_out_full = 1'b1;
                    stalls++;
                end
                tick(acc);
                guard++;
                if (!acc && guard > 300) begin
                    check_eq("feed_timeout", 32'(guard), 32'd300);
                    acc = 1'b1;
                end
            end
        end
        fifo_in_empty = 1'b1;
        fifo_out_full = 1'b0;
    endtask

    // The 8 words of a frame whose pixels are base..base+15, straight from the raster.
    task automatic check_pattern(input string tag, input int base);
        logic [DO-1:0] exp;
        check_eq({tag, "_count"}, out_q.size(), 8);
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            exp = {8'(base + 8 + i), 8'(base + 4 + i), 8'(base + i)};
            check_eq({tag, "_word"}, out_q[i], exp);
        end
        out_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        fifo_in_empty = 1'b1;
        fifo_out_full = 1'b0;
        fifo_in_dout  = '0;

        // Reset state, with pixels on offer to prove rd_en is forced low.
        do_reset(3);
        idle(2);
        out_q.delete();

        // Plain frame, no stalls.
        feed(0, NPIX, 0, 0, -1, 1'b0);
        idle(2);
        check_pattern("basic", 0);

        // Output full held on pixel 10.
        feed(0, NPIX, 0, 0, 10, 1'b0);
        idle(2);
        check_pattern("stall", 0);

        // Random input gaps.
        feed(0, NPIX, 50, 0, -1, 1'b0);
        idle(2);
        check_pattern("gaps", 0);

        // Back-to-back frames.
        feed(0, NPIX, 0, 0, -1, 1'b0);
        check_pattern("b2b_first", 0);
        feed(16, NPIX, 0, 0, -1, 1'b0);
        idle(2);
        check_pattern("b2b_second", 16);

        // Abort mid-frame after pixel 9, then a clean frame.
        feed(0, 10, 0, 0, -1, 1'b0);
        do_reset(1);
        out_q.delete();
        feed(0, NPIX, 0, 0, -1, 1'b0);
        idle(2);
        check_pattern("abort", 0);

        // Random data with random gaps and full stalls.
        for (int f = 0; f < 6; f++) begin
            out_q.delete();
            feed(0, NPIX, 30, 30, -1, 1'b1);
            idle(1);
            check_eq("rand_count", out_q.size(), 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_column_builder.md
SOBEL_COLUMN_BUILDER -- requirements
Module: sobel_column_builder

Interface
REQ-001 SHALL have parameter WIDTH, default 720, meaning pixels per image row.
REQ-002 SHALL have parameter HEIGHT, default 540, meaning rows per frame.
REQ-003 SHALL have parameter DWIDTH_IN, default 8, meaning grayscale pixel width.
REQ-004 SHALL have parameter DWIDTH_OUT, default 24, meaning column word width (3 x DWIDTH_IN).
REQ-005 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fifo_in_rd_en  output  1  pops input FIFO this cycle.
REQ-008 SHALL have port fifo_in_dout  input  DWIDTH_IN  grayscale pixel, first-word-fall-through (valid while not empty).
REQ-009 SHALL have port fifo_in_empty  input  1  input FIFO empty.
REQ-010 SHALL have port fifo_out_wr_en  output  1  pushes fifo_out_din this cycle.
REQ-011 SHALL have port fifo_out_din  output  DWIDTH_OUT  column word to the Sobel filter.
REQ-012 SHALL have port fifo_out_full  input  1  output FIFO full.
REQ-013 SHALL have port frame_done  output  1  registered one-cycle pulse after the last pixel of a frame is consumed.

Function
REQ-014 SHALL accept pixels row-major in BMP order (bottom row first, left to right), WIDTH*HEIGHT per frame.
REQ-015 SHALL assert fifo_in_rd_en combinationally iff reset=0, fifo_in_empty=0 and fifo_out_full=0; a pixel is consumed only in such a cycle ("accept").
REQ-016 SHALL hold col counter (0..WIDTH-1) and row counter (0..HEIGHT-1), advancing col on each accept, wrapping col to 0 and incrementing row at col=WIDTH-1.
REQ-017 SHALL wrap row to 0 on accepting pixel (WIDTH-1, HEIGHT-1), starting a new frame on the next accept.
REQ-018 SHALL keep two row buffers: buf_old (row r-2) and buf_mid (row r-1), each WIDTH x DWIDTH_IN, indexed by col.
REQ-019 SHALL on each accept write buf_old[col] <= buf_mid[col] and buf_mid[col] <= fifo_in_dout.
REQ-020 SHALL drive fifo_out_din = {fifo_in_dout, buf_mid[col], buf_old[col]}: [23:16] current row, [15:8] row r-1, [7:0] row r-2.
REQ-021 SHALL assert fifo_out_wr_en in the same cycle as an accept iff row >= 2; rows 0 and 1 prime buffers only.
REQ-022 SHALL produce exactly (HEIGHT-2)*WIDTH output words per frame, zero latency, no reordering.
REQ-023 SHALL never assert fifo_out_wr_en while fifo_out_full=1 nor fifo_in_rd_en while fifo_in_empty=1.
REQ-024 SHALL keep all state unchanged in non-accept cycles (empty gaps or full stalls), so output is independent of stall pattern.
REQ-025 SHALL pulse frame_done high for exactly the cycle following the accept of the last frame pixel.
REQ-026 SHALL size counters as ceil(log2(WIDTH)) and ceil(log2(HEIGHT)) bits.

Reset
REQ-027 SHALL, with reset=1, set col=0, row=0, frame_done=0, and force fifo_in_rd_en=0, fifo_out_wr_en=0.
REQ-028 SHALL leave row buffer contents uncleared; priming (REQ-021) masks stale data.
REQ-029 SHALL treat reset mid-frame as a frame abort: the next accepted pixel is (0,0) of a new frame and emits nothing for two rows.

Structure
REQ-030 SHALL take WIDTH, HEIGHT, pixel width and column-word width constants from the shared image package also used by the Sobel filter.
REQ-031 SHALL instantiate sub-module line_buffer_ram (WIDTH x DWIDTH_IN, async read, sync write, write enable) twice, for buf_old and buf_mid.

Verification (WIDTH=4, HEIGHT=4)
REQ-032 SHALL check: pixels 0..15, no stalls -> no wr_en for pixels 0..7; 8 words 24'h080400, 24'h090501, ..., last 24'h0F0B07; frame_done one cycle after pixel 15.
REQ-033 SHALL check: fifo_out_full=1 while pixel 10 presented for 5 cycles -> rd_en=0, wr_en=0 throughout; on release word 24'h0A0602 written once.
REQ-034 SHALL check: random fifo_in_empty gaps (50%) -> identical 8-word sequence as REQ-032.
REQ-035 SHALL check: back-to-back second frame 16..31 -> no output for 16..23, then 24'h181410 ... 24'h1F1B17.
REQ-036 SHALL check: reset pulse after pixel 9 accepted, then feed 0..15 -> output matches REQ-032 exactly, no stale words.
